// File: rtl/sprite_writer_if.sv
// Sprite writer bus: pixel stream in, framebuffer write port and status out.
// master = the side that feeds the block, slave = the sprite writer itself.
interface sprite_writer_if #(
  parameter int unsigned ADDR_W = 20
) ();
  logic              start;
  logic [10:0]       x;
  logic [9:0]        y;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;
  logic              busy;
  logic              done;

  modport master (
    output start, x, y, in_data, in_valid,
    input  in_ready, we, waddr, wdata, busy, done
  );

  modport slave (
    input  start, x, y, in_data, in_valid,
    output in_ready, we, waddr, wdata, busy, done
  );
endinterface

// File: rtl/sprite_writer.sv
// Sprite writer: streams a WIDTH x HEIGHT sprite in raster order into a
// framebuffer at (x, y), dropping pixels that land outside the framebuffer.
module sprite_writer #(
  parameter int unsigned WIDTH     = 400,
  parameter int unsigned HEIGHT    = 300,
  parameter int unsigned FB_WIDTH  = 1024,
  parameter int unsigned FB_HEIGHT = 768,
  parameter int unsigned ADDR_W    = 20
) (
  input logic             pixel_clk,
  input logic             reset,
  sprite_writer_if.slave  bus
);

  localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  typedef enum logic {StIdle, StLoad} state_e;

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [10:0]       x_q, x_d;
  logic [9:0]        y_q, y_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              done_q, done_d;

  logic              accept;
  logic [11:0]       dc;
  logic [10:0]       dr;
  logic              clipped;
  logic [ADDR_W-1:0] addr;

  // Destination is widened so the clip test sees the true coordinate.
  assign accept  = (state_q == StLoad) && bus.in_valid;
  assign dc      = {1'b0, x_q} + 12'(col_q);
  assign dr      = {1'b0, y_q} + 11'(row_q);
  assign clipped = (32'(dc) >= FB_WIDTH) || (32'(dr) >= FB_HEIGHT);
  assign addr    = ADDR_W'(dc) + ADDR_W'(dr) * ADDR_W'(FB_WIDTH);

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      x_q     <= x_d;
      y_q     <= y_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  // Next-state: latch origin on start, walk col/row per accepted pixel.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    x_d     = x_q;
    y_d     = y_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          x_d     = bus.x;
          y_d     = bus.y;
          col_d   = '0;
          row_d   = '0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (accept) begin
          if (!clipped) begin
            we_d    = 1'b1;
            waddr_d = addr;
            wdata_d = bus.in_data;
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
            if (row_q == ROW_LAST) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // busy stretches over the done cycle, when the FSM is already idle.
  assign bus.in_ready = (state_q == StLoad);
  assign bus.busy     = (state_q == StLoad) || done_q;
  assign bus.we       = we_q;
  assign bus.waddr    = waddr_q;
  assign bus.wdata    = wdata_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_sprite_writer.sv
// Directed bench for sprite_writer on a 4x2 sprite into an 8x4 framebuffer.
module tb_sprite_writer;

  logic pixel_clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_we[8];
  int   exp_addr[8];

  sprite_writer_if #(.ADDR_W(5)) bus ();

  sprite_writer #(
    .WIDTH    (4),
    .HEIGHT   (2),
    .FB_WIDTH (8),
    .FB_HEIGHT(4),
    .ADDR_W   (5)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_we"}, 32'(bus.we), 0);
    check({tag, "_done"}, 32'(bus.done), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_rdy"}, 32'(bus.in_ready), 0);
  endtask

  // Feed 8 pixels (data = index) against exp_we/exp_addr; returns on the done cycle.
  task automatic stream(input bit gaps, input bit poke_start);
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(k);
      if (poke_start && k == 2) begin
        bus.start = 1'b1;
        bus.x     = 11'd0;
        bus.y     = 10'd0;
      end
      step();
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      check("we", 32'(bus.we), 32'(exp_we[k]));
      if (exp_we[k] != 0) begin
        check("waddr", 32'(bus.waddr), 32'(exp_addr[k]));
        check("wdata", 32'(bus.wdata), 32'(k));
      end
      check("done", 32'(bus.done), 32'(k == 7));
      check("busy", 32'(bus.busy), 1);
      check("in_ready", 32'(bus.in_ready), 32'(k != 7));
      if (gaps && k != 7) begin
        step();
        check("gap_we", 32'(bus.we), 0);
        check("gap_rdy", 32'(bus.in_ready), 1);
        check("gap_done", 32'(bus.done), 0);
      end
    end
  endtask

  task automatic begin_load(input int xs, input int ys);
    bus.start = 1'b1;
    bus.x     = 11'(xs);
    bus.y     = 10'(ys);
    step();
    bus.start = 1'b0;
    check("load_busy", 32'(bus.busy), 1);
    check("load_rdy", 32'(bus.in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got timeout expected finish");
    $fatal(1);
  end

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    #2;
    check("rst_we", 32'(bus.we), 0);
    check("rst_waddr", 32'(bus.waddr), 0);
    check("rst_wdata", 32'(bus.wdata), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_rdy", 32'(bus.in_ready), 0);
    step();
    step();
    reset = 1'b0;

    // in_valid while idle is not consumed and writes nothing.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    step();
    step();
    check_idle("idle_valid");
    bus.in_valid = 1'b0;

    // Fully visible sprite at (2,1), back-to-back.
    exp_we   = '{1, 1, 1, 1, 1, 1, 1, 1};
    exp_addr = '{10, 11, 12, 13, 18, 19, 20, 21};
    begin_load(2, 1);
    stream(1'b0, 1'b0);
    step();
    check_idle("s1_end");

    // Sprite at (6,3): only two pixels fall inside the framebuffer.
    exp_we   = '{1, 1, 0, 0, 0, 0, 0, 0};
    exp_addr = '{30, 31, 0, 0, 0, 0, 0, 0};
    begin_load(6, 3);
    stream(1'b0, 1'b0);
    step();
    check_idle("s2_end");

    // Alternate-cycle valid; restart on the done cycle.
    exp_we   = '{1, 1, 1, 1, 1, 1, 1, 1};
    exp_addr = '{10, 11, 12, 13, 18, 19, 20, 21};
    begin_load(2, 1);
    stream(1'b1, 1'b0);
    begin_load(2, 1);
    check("restart_done", 32'(bus.done), 0);

    // Start pulsed mid-load with a different origin is ignored.
    stream(1'b0, 1'b1);
    step();
    check_idle("s4_end");

    // Reset after three accepts, then restart from the origin.
    begin_load(0, 0);
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(k + 16);
      step();
      check("pre_rst_we", 32'(bus.we), 1);
      check("pre_rst_waddr", 32'(bus.waddr), 32'(k));
    end
    reset = 1'b1;
    #1;
    check("mid_rst_we", 32'(bus.we), 0);
    check("mid_rst_waddr", 32'(bus.waddr), 0);
    check("mid_rst_wdata", 32'(bus.wdata), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    check("mid_rst_rdy", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    check_idle("post_rst");
    begin_load(0, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    step();
    bus.in_valid = 1'b0;
    check("restart_we", 32'(bus.we), 1);
    check("restart_waddr", 32'(bus.waddr), 0);
    check("restart_wdata", 32'(bus.wdata), 32'h0A5);
    check("restart_rdy", 32'(bus.in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
